uart_tx_sched: RTL and testbench

Round-robin scheduler sharing one `UART_Tx` transmitter among `NUM_REQ` byte producers. Each producer presents a byte with its own parity and baud selection; the block grants one request at a time, drives the `UART_Tx` `send`, `data_in`, `parity_type` and `baud_rate` inputs, and tracks `active_flag`/`done_flag` to sequence frames. It sits between the system-side producers and the `UART_Tx` instance, and is the only block that drives `UART_Tx` inputs.

---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_tx_sched_if.sv | 29 ++
 rtl/rr_arbiter.sv | 31 +++
 rtl/uart_tx_sched.sv | 132 +++++++++++++
 tb/tb_uart_tx_sched.sv | 432 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared constants and types for the shared-UART transmit scheduler.
// Parity/baud encodings match the UART_Tx configuration inputs.
package uart_pkg;

  localparam logic [1:0] PARITY_NONE = 2'b00;
  localparam logic [1:0] PARITY_ODD  = 2'b01;
  localparam logic [1:0] PARITY_EVEN = 2'b10;

  localparam logic [1:0] BAUD_2400  = 2'b00;
  localparam logic [1:0] BAUD_4800  = 2'b01;
  localparam logic [1:0] BAUD_9600  = 2'b10;
  localparam logic [1:0] BAUD_19200 = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT_DONE
  } sched_state_t;

  // The reserved code 11 is sent to the UART as "no parity".
  function automatic logic [1:0] norm_parity(
    input logic [1:0] p
  );
    return (p == 2'b11) ? PARITY_NONE : p;
  endfunction

endpackage

// File: rtl/uart_tx_sched_if.sv
// Producer-side request bus of the shared-UART scheduler.
// One valid/ready pair plus byte, parity and baud per requester.
interface uart_tx_sched_if #(
  parameter int NUM_REQ = 4
);

  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ*8-1:0] req_data;
  logic [NUM_REQ*2-1:0] req_parity;
  logic [NUM_REQ*2-1:0] req_baud;
  logic [NUM_REQ-1:0]   req_ready;

  modport master (
    output req_valid,
    output req_data,
    output req_parity,
    output req_baud,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_data,
    input  req_parity,
    input  req_baud,
    output req_ready
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first request at or above ptr,
// searching upward with wrap. Reusable for any shared-UART bus.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_id,
  output logic          any
);

  logic [IW-1:0] idx;

  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    any    = 1'b0;
    idx    = '0;
    for (int k = 0; k < N; k++) begin
      idx = IW'((int'(ptr) + k) % N);
      if (!any && req[idx]) begin
        any      = 1'b1;
        gnt[idx] = 1'b1;
        gnt_id   = idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART_Tx among NUM_REQ producers.
// Owns the frame FSM, inter-frame gap, start timeout and config regs.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter  int NUM_REQ       = 4,
  parameter  int GAP_CYCLES    = 16,
  parameter  int START_TIMEOUT = 1024,
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  uart_tx_sched_if.slave        req_bus,
  output logic                  tx_send,
  output logic [7:0]            tx_data,
  output logic [1:0]            tx_parity_type,
  output logic [1:0]            tx_baud_rate,
  input  logic                  tx_active,
  input  logic                  tx_done,
  output logic                  busy,
  output logic [IW-1:0]         grant_id,
  output logic                  frame_done,
  output logic                  err_timeout
);

  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam int TW = $clog2(START_TIMEOUT + 1);

  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES);
  localparam logic [TW-1:0] TO_LAST  = TW'(START_TIMEOUT - 1);
  localparam logic [IW-1:0] LAST_ID  = IW'(NUM_REQ - 1);

  sched_state_t state;
  sched_state_t state_nx;

  logic [GW-1:0]      gap_cnt;
  logic [TW-1:0]      to_cnt;
  logic [IW-1:0]      rr_ptr;
  logic [NUM_REQ-1:0] arb_gnt;
  logic [IW-1:0]      arb_id;
  logic               arb_any;
  logic               accept;
  logic               finish;
  logic               timeout;

  rr_arbiter #(
    .N(NUM_REQ)
  ) u_arb (
    .req    (req_bus.req_valid),
    .ptr    (rr_ptr),
    .gnt    (arb_gnt),
    .gnt_id (arb_id),
    .any    (arb_any)
  );

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    finish   = 1'b0;
    timeout  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        // A UART still busy from before a reset must drain first.
        if (!rst && arb_any && gap_cnt == '0 && !tx_active) begin
          accept   = 1'b1;
          state_nx = ST_SEND;
        end
      end
      ST_SEND: begin
        if (tx_done) begin
          finish   = 1'b1;
          state_nx = ST_IDLE;
        end else if (tx_active) begin
          state_nx = ST_WAIT_DONE;
        end else if (to_cnt == TO_LAST) begin
          timeout  = 1'b1;
          state_nx = ST_IDLE;
        end
      end
      ST_WAIT_DONE: begin
        if (tx_done) begin
          finish   = 1'b1;
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  assign req_bus.req_ready = accept ? arb_gnt : '0;
  assign tx_send           = (state == ST_SEND);
  assign busy              = (state != ST_IDLE) || (gap_cnt != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      tx_data        <= '0;
      tx_parity_type <= PARITY_NONE;
      tx_baud_rate   <= '0;
      grant_id       <= '0;
      rr_ptr         <= '0;
      gap_cnt        <= '0;
      to_cnt         <= '0;
      frame_done     <= 1'b0;
      err_timeout    <= 1'b0;
    end else begin
      state       <= state_nx;
      frame_done  <= finish;
      err_timeout <= timeout;
      if (accept) begin
        tx_data        <= req_bus.req_data[{arb_id, 3'b000} +: 8];
        tx_parity_type <= norm_parity(
                            req_bus.req_parity[{arb_id, 1'b0} +: 2]);
        tx_baud_rate   <= req_bus.req_baud[{arb_id, 1'b0} +: 2];
        grant_id       <= arb_id;
      end
      if (accept) begin
        to_cnt <= '0;
      end else if (state == ST_SEND) begin
        to_cnt <= to_cnt + 1'b1;
      end
      // Pointer moves only when a frame ends, by success or timeout.
      if (finish || timeout) begin
        rr_ptr  <= (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
        gap_cnt <= GAP_LOAD;
      end else if (gap_cnt != '0) begin
        gap_cnt <= gap_cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: directed frame table, timeout, reset and
// withdrawal sequences, then random traffic against a frame-level model.
module tb_uart_tx_sched;

  localparam int N   = 4;
  localparam int GAP = 16;
  localparam int ST  = 1024;
  localparam int INF = 32'h3fffffff;

  typedef struct {
    logic [3:0]  mask;
    int          nfr;
    bit          refill;
    logic [7:0]  data;
    logic [1:0]  par;
    logic [1:0]  baud;
    logic [15:0] order;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_tx_sched_if #(.NUM_REQ(N)) rq ();

  logic       tx_send;
  logic [7:0] tx_data;
  logic [1:0] tx_parity_type;
  logic [1:0] tx_baud_rate;
  logic       tx_active;
  logic       tx_done;
  logic       busy;
  logic [1:0] grant_id;
  logic       frame_done;
  logic       err_timeout;

  uart_tx_sched #(
    .NUM_REQ       (N),
    .GAP_CYCLES    (GAP),
    .START_TIMEOUT (ST)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req_bus        (rq.slave),
    .tx_send        (tx_send),
    .tx_data        (tx_data),
    .tx_parity_type (tx_parity_type),
    .tx_baud_rate   (tx_baud_rate),
    .tx_active      (tx_active),
    .tx_done        (tx_done),
    .busy           (busy),
    .grant_id       (grant_id),
    .frame_done     (frame_done),
    .err_timeout    (err_timeout)
  );

  int nvec = 0;
  int nfail = 0;
  int cyc = 0;

  // reference model of the scheduler at frame level
  bit         model_en;
  bit         m_busy;
  int         m_ptr, m_earliest, m_g, m_act, m_done, m_id;
  logic [7:0] m_data;
  logic [1:0] m_par, m_baud;

  // observation logs
  int gq_id[$];
  int gq_cyc[$];
  int dq_cyc[$];
  int sd[$];
  int sp[$];
  int sb[$];
  int fd_count, err_count, err_cyc, id3_grants, fall_cyc;
  logic send_prev;

  // producers and UART responder
  logic [N-1:0] pend_clr;
  bit refill;
  int u_st, u_cnt, u_dact, u_dlen;
  bit u_mute, u_rand;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h",
               name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr      = 0;
    m_earliest = 0;
    m_busy     = 0;
    m_act      = INF;
    m_done     = INF;
  endtask

  function automatic int winner();
    for (int k = 0; k < N; k++)
      if (rq.req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  task automatic monitor();
    int w, lim, rid;
    logic [N-1:0] exp_rdy;
    bit efd, eerr, esend, ebusy;
    cyc++;
    if (rq.req_ready != '0) begin
      rid = 0;
      for (int i = N - 1; i >= 0; i--) if (rq.req_ready[i]) rid = i;
      gq_id.push_back(rid);
      gq_cyc.push_back(cyc);
      if (rq.req_ready[3]) id3_grants++;
      pend_clr |= rq.req_ready;
    end
    if (tx_send && !send_prev) begin
      sd.push_back(int'(tx_data));
      sp.push_back(int'(tx_parity_type));
      sb.push_back(int'(tx_baud_rate));
    end
    send_prev = tx_send;
    if (tx_done) dq_cyc.push_back(cyc);
    if (frame_done) fd_count++;
    if (err_timeout) begin
      err_count++;
      err_cyc = cyc;
    end
    if (!tx_active && fall_cyc == INF) fall_cyc = cyc;
    if (model_en && !rst) begin
      if (m_busy && cyc > m_g && cyc <= m_g + ST && m_act == INF &&
          (tx_active || tx_done))
        m_act = cyc;
      efd   = m_busy && (m_done == cyc - 1);
      eerr  = m_busy && m_act == INF && cyc == m_g + 1 + ST;
      lim   = (m_act < m_g + ST) ? m_act : m_g + ST;
      esend = m_busy && cyc > m_g && cyc <= lim;
      chk("frame_done", frame_done, efd);
      chk("err_timeout", err_timeout, eerr);
      chk("tx_send", tx_send, esend);
      if (m_busy && cyc > m_g) begin
        chk("tx_data", tx_data, m_data);
        chk("tx_parity", tx_parity_type, m_par);
        chk("tx_baud", tx_baud_rate, m_baud);
      end
      if (efd || eerr) begin
        if (efd) chk("grant_id", grant_id, m_id);
        m_busy     = 0;
        m_ptr      = (m_id + 1) % N;
        m_earliest = cyc + GAP;
      end
      if (m_busy && cyc > m_g && tx_done && m_done == INF) m_done = cyc;
      ebusy = (m_busy && cyc > m_g) || cyc < m_earliest;
      chk("busy", busy, ebusy);
      w = winner();
      exp_rdy = '0;
      if (!m_busy && cyc >= m_earliest && !tx_active && w >= 0)
        exp_rdy[w] = 1'b1;
      chk("req_ready", rq.req_ready, exp_rdy);
      if (exp_rdy != '0) begin
        m_busy = 1;
        m_g    = cyc;
        m_id   = w;
        m_data = rq.req_data[w*8 +: 8];
        m_par  = rq.req_parity[w*2 +: 2];
        if (m_par == 2'b11) m_par = 2'b00;
        m_baud = rq.req_baud[w*2 +: 2];
        m_act  = INF;
        m_done = INF;
      end
    end
  endtask

  task automatic uart_update();
    case (u_st)
      0: if (tx_send && !u_mute) begin
        if (u_rand) begin
          u_dact = $urandom_range(0, 3);
          u_dlen = $urandom_range(1, 24);
        end
        if (u_dact == 0) begin
          tx_active = 1'b1;
          u_st = 2;
          u_cnt = u_dlen;
        end else begin
          u_st = 1;
          u_cnt = u_dact - 1;
        end
      end
      1: if (u_cnt == 0) begin
        tx_active = 1'b1;
        u_st = 2;
        u_cnt = u_dlen;
      end else u_cnt--;
      2: if (u_cnt == 0) begin
        tx_active = 1'b0;
        tx_done = 1'b1;
        u_st = 3;
      end else u_cnt--;
      3: begin
        tx_done = 1'b0;
        u_st = 0;
      end
      4: if (u_cnt == 0) begin
        tx_active = 1'b0;
        u_st = 0;
      end else u_cnt--;
      default: u_st = 0;
    endcase
  endtask

  task automatic step();
    #1;
    monitor();
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (pend_clr[i]) begin
        if (refill) rq.req_data[i*8 +: 8] = rq.req_data[i*8 +: 8] + 8'd1;
        else rq.req_valid[i] = 1'b0;
      end
    end
    pend_clr = '0;
    uart_update();
  endtask

  task automatic wait_grants(input int n, input int budget);
    int b = 0;
    while (gq_id.size() < n && b < budget) begin
      step();
      b++;
    end
    if (gq_id.size() < n) chk("grant_wait_expired", gq_id.size(), n);
  endtask

  task automatic wait_idle(input int budget);
    int b = 0;
    while ((busy || tx_active || u_st != 0) && b < budget) begin
      step();
      b++;
    end
    chk("idle_wait", busy, 1'b0);
  endtask

  task automatic clear_logs();
    gq_id.delete();
    gq_cyc.delete();
    dq_cyc.delete();
    sd.delete();
    sp.delete();
    sb.delete();
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_tx_send"}, tx_send, 1'b0);
    chk({tag, "_tx_data"}, tx_data, 8'h00);
    chk({tag, "_tx_parity"}, tx_parity_type, 2'b00);
    chk({tag, "_tx_baud"}, tx_baud_rate, 2'b00);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_grant_id"}, grant_id, 2'd0);
    chk({tag, "_frame_done"}, frame_done, 1'b0);
    chk({tag, "_err_timeout"}, err_timeout, 1'b0);
    chk({tag, "_req_ready"}, rq.req_ready, 4'b0000);
  endtask

  initial begin
    vecs[0] = '{4'b0001, 1, 1'b0, 8'h4A, 2'b01, 2'b10,
                {14'd0, 2'd0}};
    vecs[1] = '{4'b0110, 2, 1'b0, 8'h10, 2'b10, 2'b01,
                {12'd0, 2'd2, 2'd1}};
    vecs[2] = '{4'b1000, 1, 1'b0, 8'h20, 2'b11, 2'b11,
                {14'd0, 2'd3}};
    vecs[3] = '{4'b1111, 8, 1'b1, 8'h30, 2'b00, 2'b00,
                {2'd3, 2'd2, 2'd1, 2'd0, 2'd3, 2'd2, 2'd1, 2'd0}};
    vecs[4] = '{4'b0101, 2, 1'b0, 8'h40, 2'b01, 2'b01,
                {12'd0, 2'd2, 2'd0}};
    vecs[5] = '{4'b0011, 2, 1'b0, 8'h50, 2'b10, 2'b10,
                {12'd0, 2'd1, 2'd0}};
    vecs[6] = '{4'b1001, 2, 1'b0, 8'h60, 2'b11, 2'b00,
                {12'd0, 2'd0, 2'd3}};

    rst = 1'b1;
    tx_active = 1'b0;
    tx_done = 1'b0;
    rq.req_valid = '0;
    rq.req_data = '0;
    rq.req_parity = '0;
    rq.req_baud = '0;
    pend_clr = '0;
    refill = 0;
    send_prev = 1'b0;
    u_st = 0; u_cnt = 0; u_dact = 0; u_dlen = 8;
    u_mute = 0; u_rand = 0;
    fd_count = 0; err_count = 0; err_cyc = 0;
    id3_grants = 0; fall_cyc = INF;
    model_en = 0;
    model_reset();

    repeat (3) @(negedge clk);
    #1;
    check_outputs_zero("reset");
    rst = 1'b0;
    model_en = 1;

    // directed frame table
    for (int r = 0; r < 7; r++) begin
      clear_logs();
      u_dact = r % 2;
      u_dlen = 8;
      refill = vecs[r].refill;
      for (int i = 0; i < N; i++) begin
        rq.req_data[i*8 +: 8]   = vecs[r].data + 8'(i);
        rq.req_parity[i*2 +: 2] = vecs[r].par;
        rq.req_baud[i*2 +: 2]   = vecs[r].baud;
      end
      rq.req_valid = vecs[r].mask;
      wait_grants(vecs[r].nfr, 2000);
      rq.req_valid = '0;
      refill = 0;
      wait_idle(500);
      for (int k = 0; k < gq_id.size() && k < vecs[r].nfr; k++) begin
        chk("grant_order", gq_id[k], 32'(vecs[r].order[2*k +: 2]));
        if (k >= 1 && dq_cyc.size() >= k)
          chk("gap_timing", gq_cyc[k] - dq_cyc[k-1], GAP + 1);
        if (!vecs[r].refill && sd.size() > k) begin
          chk("row_data", sd[k], 32'(vecs[r].data + 8'(gq_id[k])));
          chk("row_parity", sp[k],
              (vecs[r].par == 2'b11) ? 0 : 32'(vecs[r].par));
          chk("row_baud", sb[k], 32'(vecs[r].baud));
        end
      end
    end

    // start timeout: UART never answers req1, req2 follows after gap
    clear_logs();
    err_count = 0;
    fd_count = 0;
    u_mute = 1;
    rq.req_data[15:8]  = 8'h71;
    rq.req_data[23:16] = 8'h72;
    rq.req_valid = 4'b0110;
    wait_grants(1, 100);
    begin
      int b = 0;
      while (err_count == 0 && b < ST + 100) begin
        step();
        b++;
      end
    end
    chk("timeout_seen", err_count, 1);
    if (gq_cyc.size() > 0)
      chk("timeout_cycle", err_cyc - gq_cyc[0], ST + 1);
    chk("timeout_no_frame_done", fd_count, 0);
    u_mute = 0;
    wait_grants(2, GAP + 50);
    if (gq_id.size() >= 2) begin
      chk("timeout_first_id", gq_id[0], 1);
      chk("timeout_next_id", gq_id[1], 2);
      chk("timeout_gap", gq_cyc[1] - err_cyc, GAP);
    end
    wait_idle(500);

    // reset during WAIT_DONE with the UART still transmitting
    clear_logs();
    u_dact = 0;
    u_dlen = 200;
    rq.req_valid = 4'b0001;
    wait_grants(1, 100);
    while (u_st != 2) step();
    repeat (5) step();
    rq.req_data[23:16] = 8'hC2;
    rq.req_data[31:24] = 8'hC3;
    rq.req_valid = 4'b1100;
    rst = 1'b1;
    model_en = 0;
    step();
    rst = 1'b0;
    u_st = 4;
    u_cnt = 50;
    u_dlen = 30;
    tx_active = 1'b1;
    model_reset();
    model_en = 1;
    #1;
    check_outputs_zero("midreset");
    clear_logs();
    fd_count = 0;
    id3_grants = 0;
    fall_cyc = INF;
    wait_grants(1, 200);
    if (gq_id.size() >= 1) begin
      chk("post_reset_id", gq_id[0], 2);
      chk("post_reset_release", gq_cyc[0], fall_cyc);
      chk("post_reset_hold", (gq_cyc[0] - cyc + 200) > 0, 1'b1);
    end

    // req3 withdrawn while req2's frame is in flight
    repeat (3) step();
    rq.req_valid[3] = 1'b0;
    wait_idle(300);
    repeat (2 * GAP) step();
    chk("withdrawn_req3", id3_grants, 0);
    chk("req2_frame_done", fd_count, 1);

    // random traffic against the model
    u_rand = 1;
    for (int t = 0; t < 3000; t++) begin
      for (int i = 0; i < N; i++) begin
        if (!rq.req_valid[i] && $urandom_range(0, 7) == 0) begin
          rq.req_data[i*8 +: 8]   = 8'($urandom_range(0, 255));
          rq.req_parity[i*2 +: 2] = 2'($urandom_range(0, 3));
          rq.req_baud[i*2 +: 2]   = 2'($urandom_range(0, 3));
          rq.req_valid[i] = 1'b1;
        end else if (rq.req_valid[i] && $urandom_range(0, 63) == 0) begin
          rq.req_valid[i] = 1'b0;
        end
      end
      step();
    end
    rq.req_valid = '0;
    wait_idle(500);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
